// File: rtl/fpu_issue_wb_sched_pkg.sv
// Shared types for the FP issue/writeback scheduler: execution classes, the
// writeback payload and the decoder-signal classifier.
package fpu_sched_pkg;

   localparam int MAX_LAT    = 8;
   localparam int LAT_IDX_W  = 4;
   localparam int DEF_ROB_W  = 6;
   localparam int DEF_PREG_W = 7;

   typedef enum logic [1:0] {
      CLS_FMA,
      CLS_FAST,
      CLS_TOINT,
      CLS_DIVSQRT
   } fp_cls_e;

   typedef struct packed {
      logic [DEF_ROB_W-1:0]  rob_idx;
      logic [DEF_PREG_W-1:0] pdst;
      logic                  wflags;
      logic [1:0]            tag;
   } wb_payload_t;

   // Decoder bits are not mutually exclusive; FMA wins, then TOINT, then FAST.
   function automatic fp_cls_e classify(input logic fma, input logic toint,
                                        input logic fastpipe, input logic fromint);
      if (fma)                       return CLS_FMA;
      else if (toint)                return CLS_TOINT;
      else if (fastpipe || fromint)  return CLS_FAST;
      else                           return CLS_DIVSQRT;
   endfunction

endpackage

// File: rtl/fpu_issue_wb_sched_if.sv
// Issue and writeback bundle between the FP decoder, the scheduler and the
// register-file write ports.
interface fpu_issue_wb_sched_if #(
   parameter int ROB_W  = 6,
   parameter int PREG_W = 7
);
   // Handshake: a uop transfers on a rising clock when io_req_valid and
   // io_req_ready are both high; io_req_ready never looks at io_req_valid, and
   // io_divsqrt_valid/io_divsqrt_ready follow the same rule toward div/sqrt.
   logic              io_flush;
   logic              io_req_valid;
   logic              io_req_ready;
   logic [ROB_W-1:0]  io_req_rob_idx;
   logic [PREG_W-1:0] io_req_pdst;
   logic              io_sigs_fma;
   logic              io_sigs_fastpipe;
   logic              io_sigs_fromint;
   logic              io_sigs_toint;
   logic              io_sigs_wflags;
   logic [1:0]        io_sigs_typeTagOut;
   logic              io_divsqrt_valid;
   logic              io_divsqrt_ready;
   logic              io_fpwb_valid;
   logic [ROB_W-1:0]  io_fpwb_rob_idx;
   logic [PREG_W-1:0] io_fpwb_pdst;
   logic              io_fpwb_wflags;
   logic [1:0]        io_fpwb_tag;
   logic              io_intwb_valid;
   logic [ROB_W-1:0]  io_intwb_rob_idx;
   logic [PREG_W-1:0] io_intwb_pdst;
   logic              io_intwb_wflags;
   logic              io_idle;

   modport master (
      output io_flush, io_req_valid, io_req_rob_idx, io_req_pdst,
             io_sigs_fma, io_sigs_fastpipe, io_sigs_fromint, io_sigs_toint,
             io_sigs_wflags, io_sigs_typeTagOut, io_divsqrt_ready,
      input  io_req_ready, io_divsqrt_valid,
             io_fpwb_valid, io_fpwb_rob_idx, io_fpwb_pdst, io_fpwb_wflags, io_fpwb_tag,
             io_intwb_valid, io_intwb_rob_idx, io_intwb_pdst, io_intwb_wflags, io_idle
   );

   modport slave (
      input  io_flush, io_req_valid, io_req_rob_idx, io_req_pdst,
             io_sigs_fma, io_sigs_fastpipe, io_sigs_fromint, io_sigs_toint,
             io_sigs_wflags, io_sigs_typeTagOut, io_divsqrt_ready,
      output io_req_ready, io_divsqrt_valid,
             io_fpwb_valid, io_fpwb_rob_idx, io_fpwb_pdst, io_fpwb_wflags, io_fpwb_tag,
             io_intwb_valid, io_intwb_rob_idx, io_intwb_pdst, io_intwb_wflags, io_idle
   );

endinterface

// File: rtl/fpu_wb_delay_line.sv
// Shift-down writeback delay line: slot k holds the op that writes back k-1
// cycles from now, so slot 1 is the registered writeback output.
module fpu_wb_delay_line
   import fpu_sched_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = wb_payload_t
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 ins,
   input  logic [LAT_IDX_W-1:0] ins_idx,
   input  T                     ins_data,
   output logic                 out_valid,
   output T                     out_data,
   output logic [DEPTH:1]       busy_next
);

   logic [DEPTH:1]   valid;
   T                 data [DEPTH:1];
   logic [DEPTH+1:1] valid_ext;
   T                 data_ext [DEPTH+1:1];

   assign valid_ext = {1'b0, valid};

   always_comb begin
      for (int k = 1; k <= DEPTH; k++) data_ext[k] = data[k];
      data_ext[DEPTH+1] = '0;
   end

   // Occupancy each slot will have after this edge's shift; an insert is legal
   // only where this is clear.
   assign busy_next = valid_ext[DEPTH+1:2];
   assign out_valid = valid[1];
   assign out_data  = data[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= '0;
         for (int k = 1; k <= DEPTH; k++) data[k] <= '0;
      end else begin
         for (int k = 1; k <= DEPTH; k++) begin
            valid[k] <= valid_ext[k+1] & ~flush;
            data[k]  <= data_ext[k+1];
            if (ins && !flush && ins_idx == LAT_IDX_W'(k)) begin
               valid[k] <= 1'b1;
               data[k]  <= ins_data;
            end
         end
      end
   end

endmodule

// File: rtl/fpu_issue_wb_sched.sv
// FP issue stage: classifies each uop, reserves its fixed-latency writeback
// slot and stalls the issuer on a write-port collision.
module fpu_issue_wb_sched
   import fpu_sched_pkg::*;
#(
   parameter int FMA_LAT   = 4,
   parameter int FAST_LAT  = 2,
   parameter int TOINT_LAT = 2,
   parameter int ROB_W     = 6,
   parameter int PREG_W    = 7
) (
   input logic                  clock,
   input logic                  reset,
   fpu_issue_wb_sched_if.slave  io
);

   typedef struct packed {
      logic [ROB_W-1:0]  rob_idx;
      logic [PREG_W-1:0] pdst;
      logic              wflags;
      logic [1:0]        tag;
   } payload_t;

   fp_cls_e                cls;
   logic                   ready;
   logic                   accept;
   logic                   fp_ins;
   logic                   int_ins;
   logic [LAT_IDX_W-1:0]   fp_idx;
   logic [FMA_LAT:1]       fp_busy;
   logic [TOINT_LAT:1]     int_busy;
   payload_t               req_data;
   payload_t               int_data;
   payload_t               fp_out;
   payload_t               int_out;
   logic                   fp_out_valid;
   logic                   int_out_valid;

   assign cls = classify(io.io_sigs_fma, io.io_sigs_toint,
                         io.io_sigs_fastpipe, io.io_sigs_fromint);

   // FMA has the longest latency, so fp_busy[FMA_LAT] is only set if a
   // longer-lived entry existed; the check is kept so the rule stays uniform.
   always_comb begin
      ready = 1'b0;
      if (!reset && !io.io_flush) begin
         case (cls)
            CLS_FMA:     ready = !fp_busy[FMA_LAT];
            CLS_FAST:    ready = !fp_busy[FAST_LAT];
            CLS_TOINT:   ready = 1'b1;
            CLS_DIVSQRT: ready = io.io_divsqrt_ready;
            default:     ready = 1'b0;
         endcase
      end
   end

   assign io.io_req_ready     = ready;
   assign io.io_divsqrt_valid = io.io_req_valid && cls == CLS_DIVSQRT && !io.io_flush && !reset;

   assign accept  = io.io_req_valid && ready;
   assign fp_ins  = accept && (cls == CLS_FMA || cls == CLS_FAST);
   assign int_ins = accept && cls == CLS_TOINT;
   assign fp_idx  = (cls == CLS_FMA) ? LAT_IDX_W'(FMA_LAT) : LAT_IDX_W'(FAST_LAT);

   assign req_data = '{rob_idx: io.io_req_rob_idx, pdst: io.io_req_pdst,
                       wflags: io.io_sigs_wflags, tag: io.io_sigs_typeTagOut};
   assign int_data = '{rob_idx: io.io_req_rob_idx, pdst: io.io_req_pdst,
                       wflags: io.io_sigs_wflags, tag: 2'b00};

   fpu_wb_delay_line #(.DEPTH(FMA_LAT), .T(payload_t)) u_fp_line (
      .clock     (clock),
      .reset     (reset),
      .flush     (io.io_flush),
      .ins       (fp_ins),
      .ins_idx   (fp_idx),
      .ins_data  (req_data),
      .out_valid (fp_out_valid),
      .out_data  (fp_out),
      .busy_next (fp_busy)
   );

   fpu_wb_delay_line #(.DEPTH(TOINT_LAT), .T(payload_t)) u_int_line (
      .clock     (clock),
      .reset     (reset),
      .flush     (io.io_flush),
      .ins       (int_ins),
      .ins_idx   (LAT_IDX_W'(TOINT_LAT)),
      .ins_data  (int_data),
      .out_valid (int_out_valid),
      .out_data  (int_out),
      .busy_next (int_busy)
   );

   assign io.io_fpwb_valid    = fp_out_valid;
   assign io.io_fpwb_rob_idx  = fp_out.rob_idx;
   assign io.io_fpwb_pdst     = fp_out.pdst;
   assign io.io_fpwb_wflags   = fp_out.wflags;
   assign io.io_fpwb_tag      = fp_out.tag;

   assign io.io_intwb_valid   = int_out_valid;
   assign io.io_intwb_rob_idx = int_out.rob_idx;
   assign io.io_intwb_pdst    = int_out.pdst;
   assign io.io_intwb_wflags  = int_out.wflags;

   // Slot 1 plus every post-shift slot covers the whole line.
   assign io.io_idle = !(fp_out_valid || (|fp_busy) || int_out_valid || (|int_busy));

endmodule

// File: tb/tb_fpu_issue_wb_sched.sv
// Directed bench for fpu_issue_wb_sched: single-op vector table plus
// hand-written collision, ordering, flush and reset sequences.
module tb_fpu_issue_wb_sched;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   fpu_issue_wb_sched_if #(.ROB_W(6), .PREG_W(7)) bus ();

   fpu_issue_wb_sched dut (
      .clock (clock),
      .reset (reset),
      .io    (bus)
   );

   typedef struct {
      logic       fma;
      logic       toint;
      logic       fastpipe;
      logic       fromint;
      logic [5:0] rob;
      logic [6:0] pdst;
      logic       wf;
      logic [1:0] tag;
      logic       div_rdy;
      logic       exp_ready;
      logic       exp_div;
      int         exp_port;
      int         exp_lat;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   function automatic vec_t mk(input int fma, input int toint, input int fastpipe,
                               input int fromint, input int rob, input int pdst,
                               input int wf, input int tag, input int div_rdy,
                               input int exp_ready, input int exp_div,
                               input int exp_port, input int exp_lat);
      vec_t v;
      v.fma       = 1'(fma);
      v.toint     = 1'(toint);
      v.fastpipe  = 1'(fastpipe);
      v.fromint   = 1'(fromint);
      v.rob       = 6'(rob);
      v.pdst      = 7'(pdst);
      v.wf        = 1'(wf);
      v.tag       = 2'(tag);
      v.div_rdy   = 1'(div_rdy);
      v.exp_ready = 1'(exp_ready);
      v.exp_div   = 1'(exp_div);
      v.exp_port  = exp_port;
      v.exp_lat   = exp_lat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input logic fma, input logic toint, input logic fastpipe,
                          input logic fromint, input logic [5:0] rob,
                          input logic [6:0] pdst, input logic wf, input logic [1:0] tag);
      bus.io_req_valid       = 1'b1;
      bus.io_sigs_fma        = fma;
      bus.io_sigs_toint      = toint;
      bus.io_sigs_fastpipe   = fastpipe;
      bus.io_sigs_fromint    = fromint;
      bus.io_req_rob_idx     = rob;
      bus.io_req_pdst        = pdst;
      bus.io_sigs_wflags     = wf;
      bus.io_sigs_typeTagOut = tag;
   endtask

   task automatic clear_req();
      bus.io_req_valid       = 1'b0;
      bus.io_sigs_fma        = 1'b0;
      bus.io_sigs_toint      = 1'b0;
      bus.io_sigs_fastpipe   = 1'b0;
      bus.io_sigs_fromint    = 1'b0;
      bus.io_req_rob_idx     = '0;
      bus.io_req_pdst        = '0;
      bus.io_sigs_wflags     = 1'b0;
      bus.io_sigs_typeTagOut = '0;
   endtask

   task automatic exp_fp(input string nm, input logic v, input logic [5:0] rob,
                         input logic [6:0] pdst, input logic wf, input logic [1:0] tag);
      chk({nm, "_fpv"}, 32'(bus.io_fpwb_valid), 32'(v));
      if (v) begin
         chk({nm, "_fprob"},  32'(bus.io_fpwb_rob_idx), 32'(rob));
         chk({nm, "_fppdst"}, 32'(bus.io_fpwb_pdst),    32'(pdst));
         chk({nm, "_fpwf"},   32'(bus.io_fpwb_wflags),  32'(wf));
         chk({nm, "_fptag"},  32'(bus.io_fpwb_tag),     32'(tag));
      end
   endtask

   task automatic exp_int(input string nm, input logic v, input logic [5:0] rob,
                          input logic [6:0] pdst, input logic wf);
      chk({nm, "_intv"}, 32'(bus.io_intwb_valid), 32'(v));
      if (v) begin
         chk({nm, "_introb"},  32'(bus.io_intwb_rob_idx), 32'(rob));
         chk({nm, "_intpdst"}, 32'(bus.io_intwb_pdst),    32'(pdst));
         chk({nm, "_intwf"},   32'(bus.io_intwb_wflags),  32'(wf));
      end
   endtask

   // Reset for two cycles while offering a div/sqrt op that must be refused.
   task automatic do_reset();
      reset = 1'b1;
      bus.io_flush = 1'b0;
      clear_req();
      bus.io_req_valid = 1'b1;
      bus.io_divsqrt_ready = 1'b1;
      cyc();
      cyc();
      chk("rst_idle",   32'(bus.io_idle),          32'd1);
      chk("rst_fpv",    32'(bus.io_fpwb_valid),    32'd0);
      chk("rst_intv",   32'(bus.io_intwb_valid),   32'd0);
      chk("rst_ready",  32'(bus.io_req_ready),     32'd0);
      chk("rst_divv",   32'(bus.io_divsqrt_valid), 32'd0);
      clear_req();
      bus.io_divsqrt_ready = 1'b0;
      reset = 1'b0;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(1,0,0,0,  5, 12, 1, 1, 0, 1, 0, 1, 4);
      vecs[1] = mk(0,0,1,0,  7,  3, 0, 2, 0, 1, 0, 1, 2);
      vecs[2] = mk(0,0,0,1,  9,100, 1, 0, 0, 1, 0, 1, 2);
      vecs[3] = mk(0,1,0,0,  3, 40, 1, 3, 0, 1, 0, 2, 2);
      vecs[4] = mk(1,1,1,0, 11, 20, 0, 2, 0, 1, 0, 1, 4);
      vecs[5] = mk(0,1,1,1, 12, 21, 0, 1, 0, 1, 0, 2, 2);
      vecs[6] = mk(0,0,0,0, 13, 22, 1, 0, 1, 1, 1, 0, 0);
      vecs[7] = mk(0,0,0,0, 14, 23, 1, 0, 0, 0, 1, 0, 0);
      vecs[8] = mk(1,0,0,0, 63,127, 0, 3, 0, 1, 0, 1, 4);

      reset = 1'b1;
      bus.io_flush = 1'b0;
      bus.io_divsqrt_ready = 1'b0;
      clear_req();

      // Single-op table: accept at cycle 0, then watch cycles 1..6.
      for (int i = 0; i < NV; i++) begin
         automatic vec_t v = vecs[i];
         do_reset();
         set_req(v.fma, v.toint, v.fastpipe, v.fromint, v.rob, v.pdst, v.wf, v.tag);
         bus.io_divsqrt_ready = v.div_rdy;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(bus.io_req_ready),     32'(v.exp_ready));
         chk($sformatf("v%0d_divv", i),  32'(bus.io_divsqrt_valid), 32'(v.exp_div));
         cyc();
         clear_req();
         bus.io_divsqrt_ready = 1'b0;
         for (int k = 1; k <= 6; k++) begin
            #1;
            exp_fp($sformatf("v%0d_c%0d", i, k), (v.exp_port == 1 && k == v.exp_lat),
                   v.rob, v.pdst, v.wf, v.tag);
            exp_int($sformatf("v%0d_c%0d", i, k), (v.exp_port == 2 && k == v.exp_lat),
                    v.rob, v.pdst, v.wf);
            chk($sformatf("v%0d_c%0d_idle", i, k), 32'(bus.io_idle),
                32'(!(v.exp_port != 0 && k <= v.exp_lat)));
            cyc();
         end
      end

      // FMA at 0 owns the cycle-4 slot; a FAST offered at 2 must stall one cycle.
      do_reset();
      set_req(1,0,0,0, 6'd1, 7'd1, 1'b0, 2'd0);
      #1 chk("col_fma_ready", 32'(bus.io_req_ready), 32'd1);
      cyc();
      clear_req();
      #1 exp_fp("col_c1", 1'b0, '0, '0, 1'b0, '0);
      chk("col_c1_idle", 32'(bus.io_idle), 32'd0);
      cyc();
      set_req(0,0,1,0, 6'd2, 7'd2, 1'b1, 2'd2);
      #1 chk("col_c2_ready", 32'(bus.io_req_ready), 32'd0);
      cyc();
      #1 chk("col_c3_ready", 32'(bus.io_req_ready), 32'd1);
      cyc();
      clear_req();
      #1 exp_fp("col_c4", 1'b1, 6'd1, 7'd1, 1'b0, 2'd0);
      cyc();
      #1 exp_fp("col_c5", 1'b1, 6'd2, 7'd2, 1'b1, 2'd2);
      cyc();
      #1 exp_fp("col_c6", 1'b0, '0, '0, 1'b0, '0);

      // FAST at 0 then FMA at 1: writebacks at 2 and 5.
      do_reset();
      for (int c = 0; c < 7; c++) begin
         if (c == 0)      set_req(0,0,1,0, 6'd30, 7'd30, 1'b0, 2'd1);
         else if (c == 1) set_req(1,0,0,0, 6'd31, 7'd31, 1'b1, 2'd0);
         else             clear_req();
         #1;
         if (c < 2) chk($sformatf("ord_c%0d_ready", c), 32'(bus.io_req_ready), 32'd1);
         if (c == 2)      exp_fp("ord_c2", 1'b1, 6'd30, 7'd30, 1'b0, 2'd1);
         else if (c == 5) exp_fp("ord_c5", 1'b1, 6'd31, 7'd31, 1'b1, 2'd0);
         else             exp_fp($sformatf("ord_c%0d", c), 1'b0, '0, '0, 1'b0, '0);
         cyc();
      end

      // Back-to-back FAST every cycle: never stalls, one writeback per cycle.
      do_reset();
      for (int c = 0; c < 9; c++) begin
         if (c < 6) set_req(0,0,0,1, 6'(10 + c), 7'(c), 1'(c), 2'(c));
         else       clear_req();
         #1;
         if (c < 6) chk($sformatf("b2b_c%0d_ready", c), 32'(bus.io_req_ready), 32'd1);
         exp_fp($sformatf("b2b_c%0d", c), (c >= 2 && c < 8),
                6'(10 + c - 2), 7'(c - 2), 1'(c - 2), 2'(c - 2));
         cyc();
      end

      // TOINT alongside an in-flight FMA uses only the integer line.
      do_reset();
      for (int c = 0; c < 6; c++) begin
         if (c == 0)      set_req(1,0,0,0, 6'd20, 7'd20, 1'b0, 2'd1);
         else if (c == 1) set_req(0,1,0,0, 6'd3, 7'd40, 1'b1, 2'd2);
         else             clear_req();
         #1;
         if (c < 2) chk($sformatf("ti_c%0d_ready", c), 32'(bus.io_req_ready), 32'd1);
         exp_int($sformatf("ti_c%0d", c), (c == 3), 6'd3, 7'd40, 1'b1);
         exp_fp($sformatf("ti_c%0d", c), (c == 4), 6'd20, 7'd20, 1'b0, 2'd1);
         cyc();
      end

      // Div/sqrt waits on the unit, then leaves without any writeback.
      do_reset();
      set_req(0,0,0,0, 6'd44, 7'd44, 1'b0, 2'd0);
      bus.io_divsqrt_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("div_wait%0d_ready", c), 32'(bus.io_req_ready),     32'd0);
         chk($sformatf("div_wait%0d_divv", c),  32'(bus.io_divsqrt_valid), 32'd1);
         cyc();
      end
      bus.io_divsqrt_ready = 1'b1;
      #1;
      chk("div_go_ready", 32'(bus.io_req_ready),     32'd1);
      chk("div_go_divv",  32'(bus.io_divsqrt_valid), 32'd1);
      cyc();
      clear_req();
      bus.io_divsqrt_ready = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         #1;
         exp_fp($sformatf("div_c%0d", c), 1'b0, '0, '0, 1'b0, '0);
         exp_int($sformatf("div_c%0d", c), 1'b0, '0, '0, 1'b0);
         chk($sformatf("div_c%0d_idle", c), 32'(bus.io_idle), 32'd1);
         cyc();
      end

      // Flush at 2: FAST writeback visible at 2 completes, FMA from 1 dies.
      do_reset();
      set_req(0,0,1,0, 6'd40, 7'd40, 1'b1, 2'd3);
      cyc();
      set_req(1,0,0,0, 6'd41, 7'd41, 1'b0, 2'd0);
      cyc();
      set_req(0,0,1,0, 6'd42, 7'd42, 1'b0, 2'd1);
      bus.io_flush = 1'b1;
      #1;
      chk("fl_c2_ready", 32'(bus.io_req_ready), 32'd0);
      exp_fp("fl_c2", 1'b1, 6'd40, 7'd40, 1'b1, 2'd3);
      cyc();
      bus.io_flush = 1'b0;
      clear_req();
      for (int c = 3; c <= 7; c++) begin
         #1;
         exp_fp($sformatf("fl_c%0d", c), 1'b0, '0, '0, 1'b0, '0);
         chk($sformatf("fl_c%0d_idle", c), 32'(bus.io_idle), 32'd1);
         cyc();
      end

      // Reset mid-flight drops the FMA the same way and reports idle.
      do_reset();
      set_req(1,0,0,0, 6'd50, 7'd50, 1'b1, 2'd1);
      cyc();
      clear_req();
      #1 chk("rmf_c1_idle", 32'(bus.io_idle), 32'd0);
      cyc();
      set_req(0,0,1,0, 6'd51, 7'd51, 1'b0, 2'd0);
      reset = 1'b1;
      #1 chk("rmf_c2_ready", 32'(bus.io_req_ready), 32'd0);
      cyc();
      reset = 1'b0;
      clear_req();
      for (int c = 3; c <= 6; c++) begin
         #1;
         exp_fp($sformatf("rmf_c%0d", c), 1'b0, '0, '0, 1'b0, '0);
         chk($sformatf("rmf_c%0d_idle", c), 32'(bus.io_idle), 32'd1);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
